// File: rtl/avr_cpu_prefetch_if.sv
// Program-memory and exec-side signals of the AVR instruction prefetch unit.
// master = prefetch unit, slave = memory plus execute stage.
interface avr_cpu_prefetch_if #(
  parameter int PC_WIDTH = 12
);
  logic                pm_req;
  logic [PC_WIDTH-1:0] pm_addr;
  logic                pm_ack;
  logic [15:0]         pm_data;
  logic [15:0]         opcode;
  logic [PC_WIDTH-1:0] opcode_pc;
  logic                opcode_valid;
  logic                hold;
  logic                rjmp_en;
  logic [11:0]         rjmp;

  modport master (
    output pm_req, pm_addr, opcode, opcode_pc, opcode_valid,
    input  pm_ack, pm_data, hold, rjmp_en, rjmp
  );

  modport slave (
    input  pm_req, pm_addr, opcode, opcode_pc, opcode_valid,
    output pm_ack, pm_data, hold, rjmp_en, rjmp
  );
endinterface

// File: rtl/avr_cpu_prefetch.sv
// AVR instruction prefetch queue: DEPTH-entry opcode FIFO with relative-jump flush.
// Define AVR_PREFETCH_BYPASS_EN to forward a completing word straight to exec when the queue is empty.
module avr_cpu_prefetch #(
  parameter int PC_WIDTH = 12,
  parameter int DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  avr_cpu_prefetch_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = (PC_WIDTH > 12) ? PC_WIDTH : 12;

  typedef logic [PC_WIDTH-1:0] pc_t;

  // Offset is sign-extended (or truncated) to the PC width; wrap is modulo 2^PC_WIDTH.
  function automatic pc_t jump_target(input pc_t pc, input logic [11:0] off);
    logic signed [OW-1:0] off_ext;
    off_ext = OW'($signed(off));
    return pc + pc_t'(1) + pc_t'(off_ext);
  endfunction

  logic [15:0]   q_op_q [DEPTH];
  pc_t           q_pc_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  pc_t           fetch_pc_q, fetch_pc_d;
  pc_t           addr_q, addr_d;
  logic          req_q, req_d;
  logic          discard_q, discard_d;

  logic          q_valid, complete, consume, redirect;
  logic          bypass_vld, push, pop, issue;
  logic          out_valid;
  logic [15:0]   out_op;
  pc_t           out_pc;

  assign q_valid  = (count_q != '0);
  assign complete = req_q && bus.pm_ack;
`ifdef AVR_PREFETCH_BYPASS_EN
  assign bypass_vld = complete && !discard_q && !q_valid;
`else
  assign bypass_vld = 1'b0;
`endif

  always_comb begin
    out_valid = q_valid;
    out_op    = q_valid ? q_op_q[head_q] : 16'h0000;
    out_pc    = q_valid ? q_pc_q[head_q] : '0;
`ifdef AVR_PREFETCH_BYPASS_EN
    if (bypass_vld) begin
      out_valid = 1'b1;
      out_op    = bus.pm_data;
      out_pc    = addr_q;
    end
`endif
  end

  assign consume  = out_valid && !bus.hold;
  assign redirect = consume && bus.rjmp_en;
  // A bypassed word consumed in its arrival cycle never enters the queue.
  assign pop      = consume && !bypass_vld;
  assign push     = complete && !discard_q && !redirect && !(bypass_vld && consume);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Issuing only when the post-edge count leaves a free slot reserves room for the reply.
  assign issue = !redirect && (!req_q || complete) && (count_d < CW'(DEPTH));

  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (complete) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
    end
    if (redirect) begin
      fetch_pc_d = jump_target(out_pc, bus.rjmp);
      if (req_q && !complete) discard_d = 1'b1;
    end else if (issue) begin
      req_d      = 1'b1;
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + pc_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
    end
  end

  // Queue storage is data-only; outputs are masked by the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op_q[tail_q] <= bus.pm_data;
      q_pc_q[tail_q] <= addr_q;
    end
  end

  assign bus.pm_req       = req_q;
  assign bus.pm_addr      = addr_q;
  assign bus.opcode       = out_op;
  assign bus.opcode_pc    = out_pc;
  assign bus.opcode_valid = out_valid;
endmodule

// File: doc/avr_cpu_prefetch.md
# avr_cpu_prefetch

Parametrised instruction prefetch unit for the AVR core, sitting between program memory and the execute stage. Keeps up to `DEPTH` fetched opcodes queued, presents the head opcode with its word address to exec, and stalls on `hold`. Applies relative-jump redirects by flushing the queue and restarting fetch at the target. Replaces the fixed single-slot fetch path and makes program-memory latency invisible to exec.

## Interface
- `PC_WIDTH`, 12: program word address width; all PC arithmetic is modulo 2^PC_WIDTH.
- `DEPTH`, 2: queue entries; power of two, minimum 2.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pm_req` output 1: program memory request outstanding (level).
- `pm_addr` output PC_WIDTH: requested word address; stable while `pm_req` is high.
- `pm_ack` input 1: request completes at the edge where `pm_req` and `pm_ack` are both high.
- `pm_data` input 16: opcode word; valid only with `pm_ack`.
- `opcode` output 16: head-of-queue opcode.
- `opcode_pc` output PC_WIDTH: word address of `opcode`.
- `opcode_valid` output 1: head entry present.
- `hold` input 1: exec stall; the head is consumed at an edge where `opcode_valid && !hold`.
- `rjmp_en` input 1: redirect; sampled only at a consuming edge.
- `rjmp` input 12: signed word offset; target = `opcode_pc` + 1 + sign-extend(`rjmp`), truncated or sign-extended to PC_WIDTH.

## Operation
- State: `fetch_pc`, `count` (0..DEPTH), `outstanding`, `discard`, circular queue of {opcode, pc} with head/tail pointers that wrap modulo DEPTH.
- **Push:** completion (`pm_req && pm_ack`) with `discard`=0 writes {`pm_data`, `pm_addr`} at the tail. `fetch_pc` was already advanced at issue.
- **Pop:** a consuming edge advances the head.
- Push and pop at the same edge leave `count` unchanged and are legal at `count`=DEPTH.
- **Issue rule:** at an edge with no outstanding request, or with the outstanding request completing, a new request is issued when `count_next` < DEPTH. Effects: `pm_req`<=1, `pm_addr`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+1. This reservation rule makes overflow impossible.
- **Redirect** (consuming edge with `rjmp_en`=1):
  - flush the queue (`count`<=0, head=tail) and set `fetch_pc` to the target;
  - if a request is outstanding and not completing at this edge, set `discard`, and its data is dropped on completion;
  - if it completes at this edge, its data is dropped;
  - the target request issues at the first edge where no non-discarded request is outstanding.
- `rjmp_en` on a non-consuming edge is ignored.
- A request cannot be withdrawn: `pm_addr` holds until `pm_ack`.
- **Reset** (asynchronous, any time, including mid-request): `pm_req`=0, `pm_addr`=0, `opcode`=0, `opcode_pc`=0, `opcode_valid`=0, `count`=0, `fetch_pc`=0, `discard`=0. An in-flight `pm_ack` after reset release with `pm_req`=0 is ignored.

## Timing
- The first request is issued at the first edge after `rst` deasserts: `pm_req`=1, `pm_addr`=0.
- Without bypass, fill latency from `pm_ack` to `opcode_valid` is 1 cycle. With zero-wait memory (`pm_ack` tied high) the queue sustains 1 opcode per cycle.
- Redirect penalty with zero-wait memory: 2 cycles from the consuming edge to `opcode_valid` at the target (1 issue edge, 1 completion edge).
- `opcode`, `opcode_pc` and `opcode_valid` are registered unless bypass is active (see Configuration).

## Configuration
- `AVR_PREFETCH_BYPASS_EN` defined:
  - when `count`=0, `discard`=0 and a completion occurs, `opcode`/`opcode_pc` are driven combinationally from `pm_data`/`pm_addr` and `opcode_valid`=1 in the same cycle;
  - if that cycle is a consuming edge, the word is not written to the queue;
  - first-opcode latency and redirect penalty each drop by 1 cycle.
- Not defined: all outputs come from queue registers; no combinational path from `pm_*` to `opcode*`.

## Test plan
- **Reset/fill:** release `rst`, `pm_ack`=1, memory[i]=0x1000+i, `hold`=0 -> `pm_addr` 0,1,2,…; `opcode_valid` rises 2 edges after release (1 with bypass); consumed opcodes 0x1000,0x1001,… with matching `opcode_pc`.
- **Backpressure:** DEPTH=4, `hold`=1 for 10 cycles -> `count` saturates at 4; `pm_req` stays low while full; exactly 4 words fetched and no loss or duplication after `hold` drops.
- **Forward jump:** consume `opcode_pc`=0x010 with `rjmp_en`=1, `rjmp`=0x005 -> queue flushed; next valid `opcode_pc`=0x016.
- **Backward jump/wrap:** `opcode_pc`=0x002, `rjmp`=0xFFA (-6) -> target 0xFFD (PC_WIDTH=12); at `opcode_pc`=0xFFF, sequential fetch wraps to 0x000.
- **Redirect during wait-state:** `pm_ack` held low 3 cycles while a redirect to 0x040 occurs -> the late data is discarded and never presented; the next request is `pm_addr`=0x040.
- **Async reset mid-request:** pull `rst` low with `pm_req`=1 and `count`=2 -> all outputs zero immediately; the restart fetches from 0x000.
